// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control unit:
// FSM states, opcode/funct values and every datapath mux-select encoding.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET   = 5'd0,
    S_FETCH   = 5'd1,
    S_IR      = 5'd2,
    S_DECODE  = 5'd3,
    S_R_EXEC  = 5'd4,
    S_R_WB    = 5'd5,
    S_ADDI    = 5'd6,
    S_I_WB    = 5'd7,
    S_ADDR    = 5'd8,
    S_LW_RD   = 5'd9,
    S_LW_MDR  = 5'd10,
    S_LW_WB   = 5'd11,
    S_SW      = 5'd12,
    S_BEQ     = 5'd13,
    S_J       = 5'd14,
    S_EXC_OP  = 5'd15,
    S_EXC_OVF = 5'd16,
    S_EXC_RD  = 5'd17,
    S_EXC_PC  = 5'd18
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [1:0] RMEM_PC     = 2'd0;
  localparam logic [1:0] RMEM_ALUOUT = 2'd1;
  localparam logic [1:0] RMEM_EXC    = 2'd2;

  localparam logic [1:0] EXC_OPCODE = 2'd0;
  localparam logic [1:0] EXC_OVF    = 2'd1;
  localparam logic [1:0] EXC_RSVD   = 2'd2;

  localparam logic       ULA_A_PC = 1'b0;
  localparam logic       ULA_A_A  = 1'b1;

  localparam logic [1:0] ULA_B_B       = 2'd0;
  localparam logic [1:0] ULA_B_4       = 2'd1;
  localparam logic [1:0] ULA_B_SEXT    = 2'd2;
  localparam logic [1:0] ULA_B_SEXT_SH = 2'd3;

  localparam logic [2:0] ULA_NONE = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;

  localparam logic [1:0] WREG_RT = 2'd0;
  localparam logic [1:0] WREG_RD = 2'd1;
  localparam logic [1:0] WREG_SP = 2'd2;

  localparam logic [1:0] WDATA_ALUOUT = 2'd0;
  localparam logic [1:0] WDATA_MDR    = 2'd1;
  localparam logic [1:0] WDATA_SP     = 2'd2;

  localparam logic [1:0] PC_ULA    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_MEM    = 2'd3;

  function automatic logic [2:0] funct_op(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ULA_ADD;
      FN_SUB:  return ULA_SUB;
      FN_AND:  return ULA_AND;
      default: return ULA_NONE;
    endcase
  endfunction

  function automatic logic is_alu_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control <-> datapath bundle: decoded fields and ULA flags in, enables and
// mux selects out. master = control unit, slave = datapath.
interface cpu_control_unit_if;
  logic [5:0] OPCODE;
  logic [5:0] FUNCT;
  logic       ULA_zero;
  logic       ULA_overflow;
  logic       PC_w, MEM_w, IR_w, REG_w, AB_w, EPC_w, ALUOUT_w, MDR_w;
  logic [1:0] M_EXCEPTION;
  logic [1:0] M_RMEM;
  logic       M_ULA_A;
  logic [1:0] M_ULA_B;
  logic [2:0] ULA_op;
  logic [1:0] M_WREG;
  logic [1:0] M_WDATA;
  logic [1:0] M_PC;

  modport master (
    input  OPCODE, FUNCT, ULA_zero, ULA_overflow,
    output PC_w, MEM_w, IR_w, REG_w, AB_w, EPC_w, ALUOUT_w, MDR_w,
    output M_EXCEPTION, M_RMEM, M_ULA_A, M_ULA_B, ULA_op, M_WREG, M_WDATA, M_PC
  );

  modport slave (
    output OPCODE, FUNCT, ULA_zero, ULA_overflow,
    input  PC_w, MEM_w, IR_w, REG_w, AB_w, EPC_w, ALUOUT_w, MDR_w,
    input  M_EXCEPTION, M_RMEM, M_ULA_A, M_ULA_B, ULA_op, M_WREG, M_WDATA, M_PC
  );
endinterface

// File: rtl/ctrl_wait_counter.sv
// Memory wait counter: cleared on each state entry, flags done when the
// count reaches MEM_WAIT-1 (MEM_WAIT legal range 1..7).
module ctrl_wait_counter #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);
  logic [2:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= 3'd0;
    else if (en && !done)
      cnt <= cnt + 3'd1;
  end

  assign done = (cnt == 3'(MEM_WAIT - 1));
endmodule

// File: rtl/cpu_control_unit.sv
// Multicycle control FSM for the MIPS-subset datapath.
// Optional: CTRL_OVERFLOW_EXC_EN enables the arithmetic-overflow exception path.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int          MEM_WAIT = 2,
  parameter logic [31:0] SP_INIT  = 32'd227
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_control_unit_if.master   bus
);
  // SP_INIT is consumed by the datapath write-data mux; kept here so both sides share one value.
  localparam logic [31:0] unused_sp_init = SP_INIT;

  state_t     state, state_next;
  logic       wait_done, in_wait;
  logic [1:0] exc_q;

`ifndef CTRL_OVERFLOW_EXC_EN
  logic unused_ovf;
  assign unused_ovf = bus.ULA_overflow;
`endif

  assign in_wait = (state == S_FETCH) || (state == S_LW_RD) || (state == S_EXC_RD);

  ctrl_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk  (clk),
    .rst  (reset),
    .clr  (state_next != state),
    .en   (in_wait),
    .done (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_RESET;
    else       state <= state_next;
  end

  // Exception cause latched at EPC write so the vector read keeps its select.
  always_ff @(posedge clk) begin
    if (reset)          exc_q <= EXC_OPCODE;
    else if (bus.EPC_w) exc_q <= bus.M_EXCEPTION;
  end

  always_comb begin
    state_next = S_RESET;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  state_next = wait_done ? S_IR : S_FETCH;
      S_IR:     state_next = S_DECODE;
      S_DECODE: begin
        case (bus.OPCODE)
          OP_RTYPE:     state_next = is_alu_funct(bus.FUNCT) ? S_R_EXEC : S_EXC_OP;
          OP_ADDI:      state_next = S_ADDI;
          OP_LW, OP_SW: state_next = S_ADDR;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_J;
          default:      state_next = S_EXC_OP;
        endcase
      end
`ifdef CTRL_OVERFLOW_EXC_EN
      S_R_EXEC: state_next = (bus.ULA_overflow && (bus.FUNCT == FN_ADD || bus.FUNCT == FN_SUB))
                             ? S_EXC_OVF : S_R_WB;
      S_ADDI:   state_next = bus.ULA_overflow ? S_EXC_OVF : S_I_WB;
      S_EXC_OVF: state_next = S_EXC_RD;
`else
      S_R_EXEC: state_next = S_R_WB;
      S_ADDI:   state_next = S_I_WB;
`endif
      S_R_WB:   state_next = S_FETCH;
      S_I_WB:   state_next = S_FETCH;
      S_ADDR:   state_next = (bus.OPCODE == OP_LW) ? S_LW_RD : S_SW;
      S_LW_RD:  state_next = wait_done ? S_LW_MDR : S_LW_RD;
      S_LW_MDR: state_next = S_LW_WB;
      S_LW_WB:  state_next = S_FETCH;
      S_SW:     state_next = S_FETCH;
      S_BEQ:    state_next = S_FETCH;
      S_J:      state_next = S_FETCH;
      S_EXC_OP: state_next = S_EXC_RD;
      S_EXC_RD: state_next = wait_done ? S_EXC_PC : S_EXC_RD;
      S_EXC_PC: state_next = S_FETCH;
      default:  state_next = S_RESET;
    endcase
  end

  always_comb begin
    bus.PC_w        = 1'b0;
    bus.MEM_w       = 1'b0;
    bus.IR_w        = 1'b0;
    bus.REG_w       = 1'b0;
    bus.AB_w        = 1'b0;
    bus.EPC_w       = 1'b0;
    bus.ALUOUT_w    = 1'b0;
    bus.MDR_w       = 1'b0;
    bus.M_EXCEPTION = EXC_OPCODE;
    bus.M_RMEM      = RMEM_PC;
    bus.M_ULA_A     = ULA_A_PC;
    bus.M_ULA_B     = ULA_B_B;
    bus.ULA_op      = ULA_NONE;
    bus.M_WREG      = WREG_RT;
    bus.M_WDATA     = WDATA_ALUOUT;
    bus.M_PC        = PC_ULA;
    case (state)
      S_RESET: begin
        bus.REG_w = 1'b1; bus.M_WREG = WREG_SP; bus.M_WDATA = WDATA_SP;
      end
      S_FETCH: begin
        bus.M_RMEM = RMEM_PC; bus.M_ULA_A = ULA_A_PC; bus.M_ULA_B = ULA_B_4; bus.ULA_op = ULA_ADD;
      end
      S_IR: begin
        bus.IR_w = 1'b1; bus.PC_w = 1'b1; bus.M_PC = PC_ULA;
      end
      S_DECODE: begin
        bus.AB_w = 1'b1; bus.ALUOUT_w = 1'b1;
        bus.M_ULA_A = ULA_A_PC; bus.M_ULA_B = ULA_B_SEXT_SH; bus.ULA_op = ULA_ADD;
      end
      S_R_EXEC: begin
        bus.M_ULA_A = ULA_A_A; bus.M_ULA_B = ULA_B_B;
        bus.ULA_op = funct_op(bus.FUNCT); bus.ALUOUT_w = 1'b1;
      end
      S_R_WB: begin
        bus.REG_w = 1'b1; bus.M_WREG = WREG_RD; bus.M_WDATA = WDATA_ALUOUT;
      end
      S_ADDI, S_ADDR: begin
        bus.M_ULA_A = ULA_A_A; bus.M_ULA_B = ULA_B_SEXT; bus.ULA_op = ULA_ADD; bus.ALUOUT_w = 1'b1;
      end
      S_I_WB: begin
        bus.REG_w = 1'b1; bus.M_WREG = WREG_RT; bus.M_WDATA = WDATA_ALUOUT;
      end
      S_LW_RD:  bus.M_RMEM = RMEM_ALUOUT;
      S_LW_MDR: bus.MDR_w = 1'b1;
      S_LW_WB: begin
        bus.REG_w = 1'b1; bus.M_WREG = WREG_RT; bus.M_WDATA = WDATA_MDR;
      end
      S_SW: begin
        bus.MEM_w = 1'b1; bus.M_RMEM = RMEM_ALUOUT;
      end
      S_BEQ: begin
        bus.M_ULA_A = ULA_A_A; bus.M_ULA_B = ULA_B_B; bus.ULA_op = ULA_SUB;
        bus.PC_w = bus.ULA_zero; bus.M_PC = PC_ALUOUT;
      end
      S_J: begin
        bus.PC_w = 1'b1; bus.M_PC = PC_JUMP;
      end
      S_EXC_OP: begin
        bus.EPC_w = 1'b1; bus.M_ULA_A = ULA_A_PC; bus.M_ULA_B = ULA_B_4;
        bus.ULA_op = ULA_SUB; bus.M_EXCEPTION = EXC_OPCODE;
      end
`ifdef CTRL_OVERFLOW_EXC_EN
      S_EXC_OVF: begin
        bus.EPC_w = 1'b1; bus.M_ULA_A = ULA_A_PC; bus.M_ULA_B = ULA_B_4;
        bus.ULA_op = ULA_SUB; bus.M_EXCEPTION = EXC_OVF;
      end
`endif
      S_EXC_RD: begin
        bus.M_RMEM = RMEM_EXC; bus.M_EXCEPTION = exc_q;
      end
      S_EXC_PC: begin
        bus.PC_w = 1'b1; bus.M_PC = PC_MEM;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-vector bench for cpu_control_unit (MEM_WAIT=2); expectations for the
// overflow path follow CTRL_OVERFLOW_EXC_EN.
module tb_cpu_control_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  cpu_control_unit_if bus ();

  cpu_control_unit #(.MEM_WAIT(2), .SP_INIT(32'd227)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [23:0] outs;
  assign outs = {bus.PC_w, bus.MEM_w, bus.IR_w, bus.REG_w, bus.AB_w, bus.EPC_w, bus.ALUOUT_w,
                 bus.MDR_w, bus.M_EXCEPTION, bus.M_RMEM, bus.M_ULA_A, bus.M_ULA_B, bus.ULA_op,
                 bus.M_WREG, bus.M_WDATA, bus.M_PC};

  // Field order: pc_w mem_w ir_w reg_w ab_w epc_w aluout_w mdr_w | exc rmem ula_a ula_b op wreg wdata mpc
  function automatic logic [23:0] mk(input logic pcw, memw, irw, regw, abw, epcw, aluw, mdrw,
                                     input logic [1:0] exc, rmem, input logic ua,
                                     input logic [1:0] ub, input logic [2:0] op,
                                     input logic [1:0] wreg, wdata, mpc);
    return {pcw, memw, irw, regw, abw, epcw, aluw, mdrw, exc, rmem, ua, ub, op, wreg, wdata, mpc};
  endfunction

  logic [23:0] E_RESET, E_FETCH, E_IR, E_DECODE, E_RWB, E_ADDR, E_IWB;
  logic [23:0] E_LWRD, E_LWMDR, E_LWWB, E_SW, E_J, E_EXCPC;

  function automatic logic [23:0] e_rexec(input logic [2:0] op);
    return mk(0,0,0,0,0,0,1,0, 2'd0,2'd0,1'b1,2'd0,op, 2'd0,2'd0,2'd0);
  endfunction
  function automatic logic [23:0] e_beq(input logic z);
    return mk(z,0,0,0,0,0,0,0, 2'd0,2'd0,1'b1,2'd0,3'b010, 2'd0,2'd0,2'd1);
  endfunction
  function automatic logic [23:0] e_exc(input logic [1:0] k);
    return mk(0,0,0,0,0,1,0,0, k,2'd0,1'b0,2'd1,3'b010, 2'd0,2'd0,2'd0);
  endfunction
  function automatic logic [23:0] e_excrd(input logic [1:0] k);
    return mk(0,0,0,0,0,0,0,0, k,2'd2,1'b0,2'd0,3'b000, 2'd0,2'd0,2'd0);
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [23:0] exp);
    @(negedge clk);
    check(tag, outs, exp);
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    bus.OPCODE = op;
    bus.FUNCT  = fn;
    cyc("fetch0", E_FETCH);
    cyc("fetch1", E_FETCH);
    cyc("ir", E_IR);
    cyc("decode", E_DECODE);
  endtask

  task automatic exc_seq(input string tag, input logic [1:0] k);
    cyc({tag, "_epc"}, e_exc(k));
    cyc({tag, "_rd0"}, e_excrd(k));
    cyc({tag, "_rd1"}, e_excrd(k));
    cyc({tag, "_pc"}, E_EXCPC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    E_RESET  = mk(0,0,0,1,0,0,0,0, 2'd0,2'd0,1'b0,2'd0,3'b000, 2'd2,2'd2,2'd0);
    E_FETCH  = mk(0,0,0,0,0,0,0,0, 2'd0,2'd0,1'b0,2'd1,3'b001, 2'd0,2'd0,2'd0);
    E_IR     = mk(1,0,1,0,0,0,0,0, 2'd0,2'd0,1'b0,2'd0,3'b000, 2'd0,2'd0,2'd0);
    E_DECODE = mk(0,0,0,0,1,0,1,0, 2'd0,2'd0,1'b0,2'd3,3'b001, 2'd0,2'd0,2'd0);
    E_RWB    = mk(0,0,0,1,0,0,0,0, 2'd0,2'd0,1'b0,2'd0,3'b000, 2'd1,2'd0,2'd0);
    E_ADDR   = mk(0,0,0,0,0,0,1,0, 2'd0,2'd0,1'b1,2'd2,3'b001, 2'd0,2'd0,2'd0);
    E_IWB    = mk(0,0,0,1,0,0,0,0, 2'd0,2'd0,1'b0,2'd0,3'b000, 2'd0,2'd0,2'd0);
    E_LWRD   = mk(0,0,0,0,0,0,0,0, 2'd0,2'd1,1'b0,2'd0,3'b000, 2'd0,2'd0,2'd0);
    E_LWMDR  = mk(0,0,0,0,0,0,0,1, 2'd0,2'd0,1'b0,2'd0,3'b000, 2'd0,2'd0,2'd0);
    E_LWWB   = mk(0,0,0,1,0,0,0,0, 2'd0,2'd0,1'b0,2'd0,3'b000, 2'd0,2'd1,2'd0);
    E_SW     = mk(0,1,0,0,0,0,0,0, 2'd0,2'd1,1'b0,2'd0,3'b000, 2'd0,2'd0,2'd0);
    E_J      = mk(1,0,0,0,0,0,0,0, 2'd0,2'd0,1'b0,2'd0,3'b000, 2'd0,2'd0,2'd2);
    E_EXCPC  = mk(1,0,0,0,0,0,0,0, 2'd0,2'd0,1'b0,2'd0,3'b000, 2'd0,2'd0,2'd3);

    reset = 1'b1;
    bus.OPCODE = 6'h00; bus.FUNCT = 6'h20; bus.ULA_zero = 1'b0; bus.ULA_overflow = 1'b0;
    for (int i = 0; i < 3; i++) cyc("reset", E_RESET);
    reset = 1'b0;

    // add overflowing in R_EXEC
    fetch_decode(6'h00, 6'h20);
    cyc("add_exec", e_rexec(3'b001));
    bus.ULA_overflow = 1'b1;
`ifdef CTRL_OVERFLOW_EXC_EN
    exc_seq("add_ovf", 2'd1);
`else
    cyc("add_wb", E_RWB);
`endif
    bus.ULA_overflow = 1'b0;

    // and ignores overflow flag
    fetch_decode(6'h00, 6'h24);
    cyc("and_exec", e_rexec(3'b011));
    bus.ULA_overflow = 1'b1;
    cyc("and_wb", E_RWB);
    bus.ULA_overflow = 1'b0;

    // sub without overflow
    fetch_decode(6'h00, 6'h22);
    cyc("sub_exec", e_rexec(3'b010));
    cyc("sub_wb", E_RWB);

    fetch_decode(6'h3F, 6'h00);
    exc_seq("badop", 2'd0);
    fetch_decode(6'h00, 6'h3F);
    exc_seq("badfn", 2'd0);

    fetch_decode(6'h04, 6'h00);
    bus.ULA_zero = 1'b1;
    cyc("beq_taken", e_beq(1'b1));
    fetch_decode(6'h04, 6'h00);
    bus.ULA_zero = 1'b0;
    cyc("beq_not", e_beq(1'b0));

    fetch_decode(6'h2B, 6'h00);
    cyc("sw_addr", E_ADDR);
    cyc("sw", E_SW);

    fetch_decode(6'h23, 6'h00);
    cyc("lw_addr", E_ADDR);
    cyc("lw_rd0", E_LWRD);
    cyc("lw_rd1", E_LWRD);
    cyc("lw_mdr", E_LWMDR);
    cyc("lw_wb", E_LWWB);

    // addi overflowing
    fetch_decode(6'h08, 6'h00);
    cyc("addi_exec", E_ADDR);
    bus.ULA_overflow = 1'b1;
`ifdef CTRL_OVERFLOW_EXC_EN
    exc_seq("addi_ovf", 2'd1);
`else
    cyc("addi_wb", E_IWB);
`endif
    bus.ULA_overflow = 1'b0;

    fetch_decode(6'h02, 6'h00);
    cyc("j", E_J);

    // reset in the middle of a load read
    fetch_decode(6'h23, 6'h00);
    cyc("lwr_addr", E_ADDR);
    cyc("lwr_rd0", E_LWRD);
    reset = 1'b1;
    cyc("lwr_reset0", E_RESET);
    cyc("lwr_reset1", E_RESET);
    reset = 1'b0;
    bus.OPCODE = 6'h02;
    fetch_decode(6'h02, 6'h00);
    cyc("j_after_rst", E_J);
    cyc("fetch_after_j", E_FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
